// File: rtl/pe_row_os_ctrl.sv
// rtl/pe_row_os_ctrl.sv - output-stationary signed MAC PE row with tile controller and serial result drain.
// Optional build macro ACC_SATURATE_EN: saturating accumulate with per-column sticky overflow flags.
module pe_row_os_ctrl #(
  parameter int NCOL  = 4,
  parameter int WDATA = 8,
  parameter int WACC  = 20,
  parameter int WK    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WK-1:0]             k_len,
  input  logic                      in_valid_W,
  input  logic [WDATA-1:0]          in_data_W,
  input  logic [NCOL*WDATA-1:0]     in_data_N,
  output logic [NCOL*WDATA-1:0]     out_data_S,
  output logic [WDATA-1:0]          out_data_E,
  output logic                      out_valid_E,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [WACC-1:0]           res_data,
  output logic [$clog2(NCOL)-1:0]   res_col,
  output logic                      res_ovf,
  output logic                      done
);

  localparam int WCOL = $clog2(NCOL);
  localparam logic [WCOL-1:0] LAST_COL = WCOL'(NCOL - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WK-1:0]        r_klen;
  logic [WCOL-1:0]      r_col;
  logic                 r_done;
  logic [NCOL-1:0]      r_vld;
  logic [WDATA-1:0]     r_wd [NCOL];
  logic [NCOL*WDATA-1:0] r_data_s;

  logic [NCOL-1:0]      w_pe_vld;
  logic [WDATA-1:0]     w_pe_wd [NCOL];
  logic [NCOL-1:0]      w_mac;
  logic [NCOL-1:0]      w_last_mac;
  logic [NCOL*WACC-1:0] w_acc_flat;
  logic                 w_start_ok;
  logic                 w_hs;
  logic                 w_hs_last;

  assign w_start_ok = start && (r_state == S_IDLE);
  assign w_hs       = (r_state == S_DRAIN) && res_ready;
  assign w_hs_last  = w_hs && (r_col == LAST_COL);

  // PE c sees the west operand c cycles after it enters the row.
  assign w_pe_vld = {r_vld[NCOL-2:0], in_valid_W};

  always_comb begin
    w_pe_wd[0] = in_data_W;
    for (int c = 1; c < NCOL; c++) begin
      w_pe_wd[c] = r_wd[c-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld    <= '0;
      r_data_s <= '0;
      for (int c = 0; c < NCOL; c++) begin
        r_wd[c] <= '0;
      end
    end else begin
      r_vld    <= w_pe_vld;
      r_data_s <= in_data_N;
      for (int c = 0; c < NCOL; c++) begin
        r_wd[c] <= w_pe_wd[c];
      end
    end
  end

`ifdef ACC_SATURATE_EN
  logic [NCOL-1:0] w_ovf_flat;
`endif

  genvar gc;
  generate
    for (gc = 0; gc < NCOL; gc++) begin : g_pe
      logic signed [WACC-1:0]      r_acc;
      logic [WK-1:0]               r_cnt;
      logic signed [2*WDATA-1:0]   w_prod;
      logic [WACC-1:0]             w_pext;
      logic [WACC-1:0]             w_sum;

      assign w_prod = $signed(w_pe_wd[gc]) * $signed(in_data_N[gc*WDATA +: WDATA]);
      assign w_pext = {{(WACC-2*WDATA){w_prod[2*WDATA-1]}}, w_prod};
      assign w_mac[gc] = (r_state == S_COMPUTE) && w_pe_vld[gc] && (r_cnt < r_klen);
      assign w_last_mac[gc] = w_mac[gc] && (r_cnt == r_klen - WK'(1));
      assign w_acc_flat[gc*WACC +: WACC] = r_acc;

`ifdef ACC_SATURATE_EN
      logic [WACC:0] w_ext;
      logic          w_clamp;
      logic          r_ovf;

      // One guard bit: a sign mismatch between the top two bits means the add overflowed.
      assign w_ext   = {r_acc[WACC-1], r_acc} + {w_pext[WACC-1], w_pext};
      assign w_clamp = w_ext[WACC] ^ w_ext[WACC-1];
      assign w_sum   = !w_clamp ? w_ext[WACC-1:0] :
                       (w_ext[WACC] ? {1'b1, {(WACC-1){1'b0}}} : {1'b0, {(WACC-1){1'b1}}});
      assign w_ovf_flat[gc] = r_ovf;

      always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
          r_ovf <= 1'b0;
        end else if (w_mac[gc] && w_clamp) begin
          r_ovf <= 1'b1;
        end
      end
`else
      assign w_sum = r_acc + w_pext;
`endif

      always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else if (w_mac[gc]) begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + WK'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_klen  <= '0;
      r_col   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_hs_last;
      if (w_start_ok) begin
        r_klen <= k_len;
        r_col  <= '0;
      end else if (w_hs) begin
        r_col <= w_hs_last ? '0 : r_col + WCOL'(1);
      end
    end
  end

  // The east-most PE sees valid last, so its final MAC means the whole row is done.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (k_len == '0) ? S_DRAIN : S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (w_last_mac[NCOL-1]) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_hs_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign out_data_S  = r_data_s;
  assign out_data_E  = r_wd[NCOL-1];
  assign out_valid_E = r_vld[NCOL-1];
  assign busy        = (r_state == S_COMPUTE) || (r_state == S_DRAIN);
  assign res_valid   = (r_state == S_DRAIN);
  assign res_col     = r_col;
  assign res_data    = res_valid ? w_acc_flat[r_col*WACC +: WACC] : '0;
  assign done        = r_done;
`ifdef ACC_SATURATE_EN
  assign res_ovf     = res_valid && w_ovf_flat[r_col];
`else
  assign res_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_pe_row_os_ctrl.sv
// tb/tb_pe_row_os_ctrl.sv - directed self-checking bench for pe_row_os_ctrl (NCOL=4, WDATA=8, WACC=20).
module tb_pe_row_os_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] k_len;
  logic        in_valid_W;
  logic [7:0]  in_data_W;
  logic [31:0] in_data_N;
  logic [31:0] out_data_S;
  logic [7:0]  out_data_E;
  logic        out_valid_E;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [19:0] res_data;
  logic [1:0]  res_col;
  logic        res_ovf;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [19:0] g_data [4];
  logic [1:0]  g_col  [4];
  logic        g_ovf  [4];
  logic        g_done, g_done2, g_busy, g_to;

  pe_row_os_ctrl #(.NCOL(4), .WDATA(8), .WACC(20), .WK(16)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid_W(in_valid_W), .in_data_W(in_data_W), .in_data_N(in_data_N),
    .out_data_S(out_data_S), .out_data_E(out_data_E), .out_valid_E(out_valid_E),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_col(res_col), .res_ovf(res_ovf), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] k);
    start = 1'b1;
    k_len = k;
    step();
    start = 1'b0;
  endtask

  task automatic send(input int n, input logic [7:0] w);
    for (int i = 0; i < n; i++) begin
      in_valid_W = 1'b1;
      in_data_W  = w;
      step();
    end
    in_valid_W = 1'b0;
    in_data_W  = 8'd0;
  endtask

  // Accept all four results with res_ready high and record what was seen.
  task automatic collect();
    int cyc;
    g_to = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      while (!res_valid && cyc < 300) begin
        step();
        cyc++;
      end
      if (cyc >= 300) g_to = 1'b1;
      g_data[i] = res_data;
      g_col[i]  = res_col;
      g_ovf[i]  = res_ovf;
      step();
    end
    g_done = done;
    g_busy = busy;
    step();
    g_done2 = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; k_len = 16'd0; in_valid_W = 1'b0; in_data_W = 8'd0;
    in_data_N = 32'd0; res_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    n_tests++;
    if ({out_data_S, out_data_E, out_valid_E, busy, res_valid, res_data, res_col, res_ovf, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%0b res_valid=%0b res_data=%h done=%0b out_valid_E=%0b, required all 0",
               busy, res_valid, res_data, done, out_valid_E);
    end
  endtask

  task automatic test_basic();
    logic [19:0] exp_d [4];
    exp_d = '{20'd3, 20'd6, 20'd9, 20'd12};
    in_data_N = {8'd4, 8'd3, 8'd2, 8'd1};
    do_start(16'd1);
    send(1, 8'd3);
    step(); step(); step();
    n_tests++;
    if (out_valid_E !== 1'b1 || out_data_E !== 8'd3) begin
      n_fail++;
      $display("FAIL basic_east: valid=%0b data=%0d, required 1 and 3", out_valid_E, out_data_E);
    end
    n_tests++;
    if (out_data_S !== 32'h04030201) begin
      n_fail++;
      $display("FAIL basic_south: got %h, required 04030201", out_data_S);
    end
    collect();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (g_data[i] !== exp_d[i] || g_col[i] !== 2'(i) || g_to) begin
        n_fail++;
        $display("FAIL basic_res%0d: data=%0d col=%0d timeout=%0b, required %0d col %0d", i, g_data[i], g_col[i], g_to, exp_d[i], i);
      end
    end
    n_tests++;
    if (g_done !== 1'b1 || g_busy !== 1'b0 || g_done2 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%0b busy=%0b done_next=%0b, required 1 0 0", g_done, g_busy, g_done2);
    end
  endtask

  task automatic test_depth();
    in_data_N = {4{8'd5}};
    do_start(16'd4);
    send(5, 8'hFE);
    collect();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (g_data[i] !== 20'hFFFD8 || g_col[i] !== 2'(i)) begin
        n_fail++;
        $display("FAIL depth_res%0d: data=%h col=%0d, required FFFD8 col %0d", i, g_data[i], g_col[i], i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] exp_d [4];
    int cyc;
    exp_d = '{20'd14, 20'd28, 20'd42, 20'd56};
    in_data_N = {8'd8, 8'd6, 8'd4, 8'd2};
    res_ready = 1'b0;
    do_start(16'd1);
    send(1, 8'd7);
    cyc = 0;
    while (!res_valid && cyc < 50) begin step(); cyc++; end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (res_valid !== 1'b1 || res_col !== 2'd1 || res_data !== 20'd28) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%0b col=%0d data=%0d, required 1 col 1 data 28", i, res_valid, res_col, res_data);
      end
      step();
    end
    collect();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (g_data[i] !== exp_d[i+1] || g_col[i] !== 2'(i+1)) begin
        n_fail++;
        $display("FAIL bp_res%0d: data=%0d col=%0d, required %0d col %0d", i+1, g_data[i], g_col[i], exp_d[i+1], i+1);
      end
    end
    n_tests++;
    if (g_done !== 1'b0 && g_busy !== 1'b1 && g_data[3] !== 20'd0) begin
      n_fail++;
      $display("FAIL bp_tail: extra result data=%0d", g_data[3]);
    end
  endtask

  task automatic test_edge();
    in_data_N = {4{8'd9}};
    do_start(16'd0);
    n_tests++;
    if (res_valid !== 1'b1 || busy !== 1'b1 || res_col !== 2'd0) begin
      n_fail++;
      $display("FAIL k0_drain: valid=%0b busy=%0b col=%0d, required 1 1 0", res_valid, busy, res_col);
    end
    start = 1'b1;
    k_len = 16'd3;
    in_valid_W = 1'b1;
    in_data_W  = 8'd11;
    res_ready = 1'b0;
    step();
    start = 1'b0;
    in_valid_W = 1'b0;
    in_data_W  = 8'd0;
    collect();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (g_data[i] !== 20'd0 || g_col[i] !== 2'(i)) begin
        n_fail++;
        $display("FAIL k0_res%0d: data=%0d col=%0d, required 0 col %0d", i, g_data[i], g_col[i], i);
      end
    end
    n_tests++;
    if (g_done !== 1'b1 || g_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL k0_done: done=%0b busy=%0b, required 1 0", g_done, g_busy);
    end
  endtask

  task automatic test_overflow();
    logic [19:0] exp_d;
    logic        exp_o;
`ifdef ACC_SATURATE_EN
    exp_d = 20'd524287;
    exp_o = 1'b1;
`else
    exp_d = 20'h9D828;
    exp_o = 1'b0;
`endif
    in_data_N = {4{8'd127}};
    do_start(16'd40);
    send(40, 8'd127);
    collect();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (g_data[i] !== exp_d || g_ovf[i] !== exp_o) begin
        n_fail++;
        $display("FAIL ovf_res%0d: data=%h ovf=%0b, required %h ovf %0b", i, g_data[i], g_ovf[i], exp_d, exp_o);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int cyc;
    in_data_N = {8'd1, 8'd1, 8'd1, 8'd1};
    res_ready = 1'b0;
    do_start(16'd1);
    send(1, 8'd5);
    cyc = 0;
    while (!res_valid && cyc < 50) begin step(); cyc++; end
    res_ready = 1'b1;
    step();
    n_tests++;
    if (res_col !== 2'd1 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: col=%0d valid=%0b, required col 1 valid 1", res_col, res_valid);
    end
    rst = 1'b1;
    in_valid_W = 1'b1;
    step();
    rst = 1'b0;
    in_valid_W = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || out_valid_E !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: busy=%0b res_valid=%0b out_valid_E=%0b done=%0b, required all 0", busy, res_valid, out_valid_E, done);
    end
    step();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_nodone: done=%0b, required 0", done);
    end
    in_data_N = {8'd2, 8'd3, 8'd4, 8'd5};
    do_start(16'd1);
    send(1, 8'hFF);
    collect();
    n_tests++;
    if (g_data[0] !== 20'hFFFFB || g_data[3] !== 20'hFFFFE || g_done !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_restart: res0=%h res3=%h done=%0b, required FFFFB FFFFE 1", g_data[0], g_data[3], g_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_depth();
    test_backpressure();
    test_edge();
    test_overflow();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
